// File: rtl/decoder3to8_pipe.sv
// Registered 3-to-8 decoder: 3-bit codes enter through a 2-entry FIFO and leave as
// one-hot words over a valid/ready handshake, with a delivered-word counter.
module decoder3to8_pipe #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_onehot,
    output logic [2:0]       out_code,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [1:0][2:0]  mem_q, mem_d;
    logic [1:0]       occ_q, occ_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready   = en & ~rst & (occ_q != 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_code   = mem_q[rd_ptr_q];
    assign out_onehot = out_valid ? (8'h01 << out_code) : 8'h00;
    assign count      = count_q;

    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        mem_d    = mem_q;
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_code;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            count_d  = count_q + CNT_W'(1);
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/decoder3to8_pipe.md
Name: decoder3to8_pipe

Overview:
- Registered 3-to-8 decoder: the receive-side counterpart of the team's 8-to-3 encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents each code as an 8-bit one-hot word on a valid/ready output, so encoded line numbers can be re-expanded across a pipeline stage without dropping or duplicating codes.
- Counts delivered words for debug.

Parameters:
- CNT_W, 8, width of the delivered-word counter (1..32).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  accept enable. When low, no new codes are accepted; buffered codes still drain.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  3  encoded line number, 0..7.
- in_ready  output  1  block can accept a code this cycle.
- out_valid  output  1  out_onehot holds a decoded word.
- out_onehot  output  8  one-hot decode of the head code: bit k set for code k.
- out_code  output  3  head code, raw (for checking).
- out_ready  input  1  downstream consumes the word this cycle.
- count  output  CNT_W  number of words delivered since reset, modulo 2^CNT_W.

Behaviour:
- Reset: synchronous, active-high; sampled on the rising edge of clk. All state is cleared on the next edge with rst high.
  - During reset: occupancy=0, rd_ptr=wr_ptr=0, out_valid=0, out_onehot=8'h00, out_code=3'd0, count=0, in_ready=0 (forced low while rst is high).
- Storage:
  - 2-entry FIFO of 3-bit codes, with registered occupancy (0..2) and 1-bit read/write pointers.
  - Pointers wrap 1 -> 0.
- in_ready = en & ~rst & (occupancy != 2).
  - Depends only on registered state and en; there is no combinational path from out_ready to in_ready.
- Push: in_valid & in_ready at an edge. in_code is written at wr_ptr, and wr_ptr advances.
- Pop: out_valid & out_ready at an edge. rd_ptr advances, and count increments (wraps 2^CNT_W-1 -> 0).
- Outputs:
  - out_valid = (occupancy != 0).
  - out_code = entry at rd_ptr.
  - out_onehot = 8'h01 << out_code when out_valid, else 8'h00.
  - Never more than one bit set. All-zero only when invalid.
- Latency: a code pushed at edge N is visible on out_valid/out_onehot after edge N (one cycle), provided the FIFO was empty.
- Throughput: 1 word/cycle sustained when in_valid=1 and out_ready=1 continuously. With occupancy 1, simultaneous push and pop leaves occupancy at 1.
- Occupancy update on each edge:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Full (occupancy 2): in_ready=0, and in_code is ignored even if in_valid=1. No overwrite.
- Empty (occupancy 0): out_valid=0. out_ready is ignored, and count does not change.
- Handshake rules (output side):
  - Once out_valid=1, out_code/out_onehot hold stable until popped.
  - out_valid does not drop without a pop, except on reset.
- en deasserted mid-stream: the current edge takes no new push; already-buffered words still pop normally.
- Reset mid-operation: buffered codes are discarded, count is cleared, and no partial word is delivered.
- in_code X/unknown values are not checked. Upstream must present a valid 3-bit code with in_valid.

Test Plan:
- Reset, then en=1, in_valid=1 with in_code=0..7 on consecutive cycles, out_ready=1 -> out_onehot = 01,02,04,08,10,20,40,80 one cycle after each push; count=8 at end; in_ready stays 1.
- out_ready=0, push codes 3,5,6 -> 3 and 5 accepted; in_ready=0 after the second push; 6 is not accepted. out_onehot=8'h08 held. Raise out_ready -> 8'h08, then 8'h20; count +2.
- Occupancy 1 (code 2 buffered), simultaneous push of 7 and pop -> next cycle out_onehot=8'h80, occupancy 1, count +1.
- 2 codes buffered, en=0, out_ready=1 -> both drain (correct one-hot values), in_ready=0 throughout, out_valid=0 afterwards.
- CNT_W=2: deliver 5 words -> count sequence 1,2,3,0,1.
- 2 codes buffered, rst=1 for one cycle -> out_valid=0, out_onehot=0, count=0, in_ready=0 during rst; afterwards a new push of code 4 yields 8'h10 only.
